// File: rtl/conv_operand_feeder_pkg.sv
// Shared constants and FSM encoding for the convolution operand feeder
// and the accumulator that consumes its operand stream.
package conv_operand_feeder_pkg;

   localparam int CONV_DW    = 8;
   localparam int CONV_IMG_W = 4;
   localparam int CONV_KER   = 3;
   localparam int CONV_OUT_W = CONV_IMG_W - CONV_KER + 1;
   localparam int CONV_AW    = 5;   // load address width on the bus
   localparam int CONV_IDX_W = 2;   // output pixel index width on the bus

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } conv_state_e;

   // Index width for n entries, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_operand_feeder_if.sv
// Load/control bus and operand stream of the convolution operand feeder.
// master = the side that loads memories and starts passes,
// slave  = the feeder itself.
interface conv_operand_feeder_if
   import conv_operand_feeder_pkg::*;
#(
   parameter int DW    = CONV_DW,
   parameter int IDX_W = CONV_IDX_W
);

   logic               ld_en;
   logic               ld_sel;
   logic [CONV_AW-1:0] ld_addr;
   logic [DW-1:0]      ld_data;
   logic               start;

   logic [DW-1:0]      mul_a;
   logic [DW-1:0]      mul_b;
   logic               op_valid;
   logic               op_first;
   logic               op_last;
   logic [IDX_W-1:0]   out_idx;
   logic               busy;
   logic               done;

   modport master (
      output ld_en, ld_sel, ld_addr, ld_data, start,
      input  mul_a, mul_b, op_valid, op_first, op_last, out_idx, busy, done
   );

   modport slave (
      input  ld_en, ld_sel, ld_addr, ld_data, start,
      output mul_a, mul_b, op_valid, op_first, op_last, out_idx, busy, done
   );

endinterface

// File: rtl/conv_window_counter.sv
// Nested window counters: kernel column (kc) inside kernel row (kr) form the
// tap, inside output column (ocol), inside output row (orow). The next
// position is exported so the feeder can register the operand pair for it
// in the same edge the counters move.
module conv_window_counter
   import conv_operand_feeder_pkg::*;
#(
   parameter  int KER   = CONV_KER,
   parameter  int OUT_W = CONV_OUT_W,
   localparam int KW    = clog2_min1(KER),
   localparam int OW    = clog2_min1(OUT_W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,        // return to the first position
   input  logic          adv,        // step to the following position
   output logic [KW-1:0] nxt_kr,
   output logic [KW-1:0] nxt_kc,
   output logic [OW-1:0] nxt_orow,
   output logic [OW-1:0] nxt_ocol,
   output logic          nxt_first,  // next position is tap 0 of a group
   output logic          nxt_last,   // next position is the final tap
   output logic          pass_end    // current position is the final pair
);

   localparam logic [KW-1:0] KMAX = KW'(KER - 1);
   localparam logic [OW-1:0] OMAX = OW'(OUT_W - 1);

   logic [KW-1:0] kr, kc;
   logic [OW-1:0] orow, ocol;
   logic          tap_wrap, col_wrap;

   assign tap_wrap = (kr == KMAX) && (kc == KMAX);
   assign col_wrap = tap_wrap && (ocol == OMAX);
   assign pass_end = col_wrap && (orow == OMAX);

   // Compute the position the counters take at the next edge.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned and a latch cannot be inferred.
      nxt_kr   = kr;
      nxt_kc   = kc;
      nxt_orow = orow;
      nxt_ocol = ocol;
      if (clr) begin
         nxt_kr   = '0;
         nxt_kc   = '0;
         nxt_orow = '0;
         nxt_ocol = '0;
      end else if (adv) begin
         if (kc != KMAX) begin
            nxt_kc = kc + 1'b1;
         end else begin
            nxt_kc = '0;
            if (kr != KMAX) begin
               nxt_kr = kr + 1'b1;
            end else begin
               nxt_kr = '0;
               if (ocol != OMAX) begin
                  nxt_ocol = ocol + 1'b1;
               end else begin
                  nxt_ocol = '0;
                  nxt_orow = (orow != OMAX) ? orow + 1'b1 : '0;
               end
            end
         end
      end
   end

   assign nxt_first = (nxt_kr == '0) && (nxt_kc == '0);
   assign nxt_last  = (nxt_kr == KMAX) && (nxt_kc == KMAX);

   // Hold the current window position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kr   <= '0;
         kc   <= '0;
         orow <= '0;
         ocol <= '0;
      end else begin
         // NOTE: <= makes every flop sample pre-edge values, independent of statement order.
         kr   <= nxt_kr;
         kc   <= nxt_kc;
         orow <= nxt_orow;
         ocol <= nxt_ocol;
      end
   end

endmodule

// File: rtl/conv_operand_feeder.sv
// Convolution operand feeder: holds a square image and kernel loaded byte by
// byte, then on start streams every (image, kernel) pair of a valid
// convolution one per cycle with no gaps, because the downstream accumulator
// groups purely by counting taps.
module conv_operand_feeder
   import conv_operand_feeder_pkg::*;
#(
   parameter int DW    = CONV_DW,
   parameter int IMG_W = CONV_IMG_W,
   parameter int KER   = CONV_KER
) (
   input  logic                clk,
   input  logic                rst,
   conv_operand_feeder_if.slave bus
);

   localparam int OUT_W  = IMG_W - KER + 1;
   localparam int IMG_N  = IMG_W * IMG_W;
   localparam int KER_N  = KER * KER;
   localparam int IMG_AW = clog2_min1(IMG_N);
   localparam int KER_AW = clog2_min1(KER_N);
   localparam int KW     = clog2_min1(KER);
   localparam int OW     = clog2_min1(OUT_W);
   localparam int IDX_W  = clog2_min1(OUT_W * OUT_W);

   conv_state_e state;

   logic [DW-1:0] img_mem [IMG_N];
   logic [DW-1:0] ker_mem [KER_N];

   logic [KW-1:0]     nxt_kr, nxt_kc;
   logic [OW-1:0]     nxt_orow, nxt_ocol;
   logic              nxt_first, nxt_last, pass_end;
   logic              clr, adv, issue;
   logic [IMG_AW-1:0] img_addr;
   logic [KER_AW-1:0] ker_addr;

   logic [DW-1:0]     mul_a_q, mul_b_q;
   logic              valid_q, first_q, last_q, busy_q, done_q;
   logic [IDX_W-1:0]  idx_q;

   // Counters rest at the first position outside a pass and step while
   // pairs remain; after the final pair they return to zero.
   assign adv   = (state == ST_RUN) && !pass_end;
   assign clr   = (state != ST_RUN) || pass_end;
   assign issue = ((state == ST_IDLE) && bus.start) || adv;

   conv_window_counter #(
      .KER   (KER),
      .OUT_W (OUT_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .adv       (adv),
      .nxt_kr    (nxt_kr),
      .nxt_kc    (nxt_kc),
      .nxt_orow  (nxt_orow),
      .nxt_ocol  (nxt_ocol),
      .nxt_first (nxt_first),
      .nxt_last  (nxt_last),
      .pass_end  (pass_end)
   );

   assign img_addr = IMG_AW'((int'(nxt_orow) + int'(nxt_kr)) * IMG_W
                             + int'(nxt_ocol) + int'(nxt_kc));
   assign ker_addr = KER_AW'(int'(nxt_kr) * KER + int'(nxt_kc));

   // Byte loads land only while idle; addresses past the selected memory are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the operand memories are cleared with the control state so a reset never leaves stale operands.
         for (int i = 0; i < IMG_N; i++) img_mem[i] <= '0;
         for (int i = 0; i < KER_N; i++) ker_mem[i] <= '0;
      end else if ((state == ST_IDLE) && bus.ld_en) begin
         if (!bus.ld_sel && (int'(bus.ld_addr) < IMG_N))
            img_mem[bus.ld_addr[IMG_AW-1:0]] <= bus.ld_data;
         else if (bus.ld_sel && (int'(bus.ld_addr) < KER_N))
            ker_mem[bus.ld_addr[KER_AW-1:0]] <= bus.ld_data;
      end
   end

   // Pass sequencing plus the registered operand pair and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state  <= ST_RUN;
                  busy_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (pass_end) begin
                  state  <= ST_FIN;
                  done_q <= 1'b1;
               end
            end
            ST_FIN: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase

         if (issue) begin
            valid_q <= 1'b1;
            first_q <= nxt_first;
            last_q  <= nxt_last;
            idx_q   <= IDX_W'(int'(nxt_orow) * OUT_W + int'(nxt_ocol));
            mul_a_q <= img_mem[img_addr];
            mul_b_q <= ker_mem[ker_addr];
         end else begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
         end
      end
   end

   assign bus.mul_a    = mul_a_q;
   assign bus.mul_b    = mul_b_q;
   assign bus.op_valid = valid_q;
   assign bus.op_first = first_q;
   assign bus.op_last  = last_q;
   assign bus.out_idx  = idx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule
